// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: 2-entry skid buffer with valid/ready on both sides,
// branch/jump resolution producing a one-cycle PC redirect, and jump link rewrite.
module ex_mem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 9,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [DATA_WIDTH-1:0]     ex_alu_result,
    input  logic [DATA_WIDTH-1:0]     ex_store_data,
    input  logic [DATA_WIDTH-1:0]     ex_imm,
    input  logic [PC_WIDTH-1:0]       ex_pc,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic [5:0]                ex_ctrl,
    input  logic                      flush,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [DATA_WIDTH-1:0]     mem_alu_result,
    output logic [DATA_WIDTH-1:0]     mem_store_data,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd,
    output logic [3:0]                mem_ctrl,
    output logic                      redirect_valid,
    output logic [PC_WIDTH-1:0]       redirect_pc
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     alu;
        logic [DATA_WIDTH-1:0]     sdata;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [3:0]                ctrl;
    } entry_t;

    entry_t main_q, skid_q, in_entry;
    logic   main_v, skid_v;

    logic                is_branch, is_jump, taken;
    logic                accept, xfer;
    logic [PC_WIDTH-1:0] pc_plus4, target;

    assign is_branch = ex_ctrl[5];
    assign is_jump   = ex_ctrl[4];

    assign accept = ex_valid & ex_ready & ~flush;
    assign xfer   = main_v & mem_ready;

    assign pc_plus4 = ex_pc + PC_WIDTH'(4);
    assign target   = ex_pc + ex_imm[PC_WIDTH-1:0];
    assign taken    = is_jump | (is_branch & ex_alu_result[0]);

    always_comb begin
        in_entry       = '0;
        in_entry.alu   = is_jump ? DATA_WIDTH'(pc_plus4) : ex_alu_result;
        in_entry.sdata = ex_store_data;
        in_entry.rd    = ex_rd;
        // branches never touch memory or the register file
        in_entry.ctrl  = {ex_ctrl[3] & ~is_branch,
                          ex_ctrl[2] & ~is_branch,
                          ex_ctrl[1] & ~is_branch,
                          ex_ctrl[0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            ex_ready <= 1'b1;
        end else if (flush) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            ex_ready <= 1'b1;
        end else if (skid_v) begin
            // ex_ready is low here, so no accept can coincide with the skid drain
            if (xfer) begin
                main_q   <= skid_q;
                skid_v   <= 1'b0;
                ex_ready <= 1'b1;
            end
        end else if (!main_v || xfer) begin
            main_v <= accept;
            if (accept) begin
                main_q <= in_entry;
            end
        end else if (accept) begin
            skid_q   <= in_entry;
            skid_v   <= 1'b1;
            ex_ready <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept & taken;
            if (accept && taken) begin
                redirect_pc <= target;
            end
        end
    end

    assign mem_valid      = main_v;
    assign mem_alu_result = main_q.alu;
    assign mem_store_data = main_q.sdata;
    assign mem_rd         = main_q.rd;
    assign mem_ctrl       = main_q.ctrl;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: reset, streaming, backpressure,
// branch/jump redirect, flush and mid-operation reset.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [31:0] ex_imm;
    logic [8:0]  ex_pc;
    logic [4:0]  ex_rd;
    logic [5:0]  ex_ctrl;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic [3:0]  mem_ctrl;
    logic        redirect_valid;
    logic [8:0]  redirect_pc;

    int total  = 0;
    int passed = 0;

    ex_mem_stage #(
        .DATA_WIDTH    (32),
        .PC_WIDTH      (9),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_imm        (ex_imm),
        .ex_pc         (ex_pc),
        .ex_rd         (ex_rd),
        .ex_ctrl       (ex_ctrl),
        .flush         (flush),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_alu_result(mem_alu_result),
        .mem_store_data(mem_store_data),
        .mem_rd        (mem_rd),
        .mem_ctrl      (mem_ctrl),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] alu, input logic [8:0] pc,
                        input logic [31:0] imm, input logic [5:0] ctrl);
        ex_valid      = 1'b1;
        ex_alu_result = alu;
        ex_store_data = alu ^ 32'hA5A5_0000;
        ex_imm        = imm;
        ex_pc         = pc;
        ex_rd         = alu[4:0];
        ex_ctrl       = ctrl;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; mem_ready = 1'b1;
        send(32'h99, 9'h000, 32'h0, 6'b000010);

        // reset held with a valid input present
        step(); step();
        check("rst_mem_valid", mem_valid, 0);
        check("rst_ex_ready", ex_ready, 1);
        check("rst_redirect", redirect_valid, 0);
        check("rst_alu", mem_alu_result, 0);
        check("rst_rpc", redirect_pc, 0);

        reset = 1'b1;
        step();
        check("first_valid", mem_valid, 1);
        check("first_alu", mem_alu_result, 32'h99);
        ex_valid = 1'b0;
        step();
        check("first_drain", mem_valid, 0);

        // streaming at full rate
        send(32'd5, 9'h0, 32'h0, 6'b000010); step();
        check("s5_alu", mem_alu_result, 5);
        check("s5_sdata", mem_store_data, 32'hA5A5_0005);
        check("s5_rd", mem_rd, 5);
        check("s5_ready", ex_ready, 1);
        send(32'd6, 9'h0, 32'h0, 6'b000010); step();
        check("s6_alu", mem_alu_result, 6);
        check("s6_valid", mem_valid, 1);
        send(32'd7, 9'h0, 32'h0, 6'b000010); step();
        check("s7_alu", mem_alu_result, 7);
        check("s7_ready", ex_ready, 1);
        ex_valid = 1'b0; step();
        check("s_drain", mem_valid, 0);

        // backpressure: A into main, B into skid, C held at EX
        mem_ready = 1'b0;
        send(32'h11, 9'h0, 32'h0, 6'b000010); step();
        check("bp_a_alu", mem_alu_result, 32'h11);
        check("bp_a_ready", ex_ready, 1);
        send(32'h22, 9'h0, 32'h0, 6'b000010); step();
        check("bp_b_ready", ex_ready, 0);
        check("bp_b_hold", mem_alu_result, 32'h11);
        send(32'h33, 9'h0, 32'h0, 6'b000010); step();
        check("bp_c_hold", mem_alu_result, 32'h11);
        check("bp_c_ready", ex_ready, 0);
        mem_ready = 1'b1; step();
        check("bp_out_b", mem_alu_result, 32'h22);
        check("bp_out_b_rdy", ex_ready, 1);
        step();
        check("bp_out_c", mem_alu_result, 32'h33);
        check("bp_out_c_v", mem_valid, 1);
        ex_valid = 1'b0; step();
        check("bp_drain", mem_valid, 0);

        // taken branch: write enables stripped, mem_unsigned kept
        send(32'h1, 9'h010, 32'h20, 6'b101111); step();
        check("br_redir", redirect_valid, 1);
        check("br_rpc", redirect_pc, 9'h030);
        check("br_ctrl", mem_ctrl, 4'b0001);
        ex_valid = 1'b0; step();
        check("br_pulse_end", redirect_valid, 0);
        check("br_rpc_hold", redirect_pc, 9'h030);
        // not-taken branch
        send(32'h0, 9'h010, 32'h20, 6'b101111); step();
        check("brnt_redir", redirect_valid, 0);
        check("brnt_ctrl", mem_ctrl, 4'b0001);
        ex_valid = 1'b0; step();

        // jump with wraparound, accepted while MEM stalls
        mem_ready = 1'b0;
        send(32'h1234_5678, 9'h1FC, 32'hFFFF_FFF8, 6'b010010); step();
        check("j_redir", redirect_valid, 1);
        check("j_rpc", redirect_pc, 9'h1F4);
        check("j_link", mem_alu_result, 32'h0);
        check("j_ctrl", mem_ctrl, 4'b0010);
        ex_valid = 1'b0; step();
        check("j_pulse_end", redirect_valid, 0);
        check("j_stable", mem_alu_result, 32'h0);
        send(32'h0, 9'h010, 32'h0000_0100, 6'b010010); step();
        check("j2_skid_rdy", ex_ready, 0);
        check("j2_rpc", redirect_pc, 9'h110);
        mem_ready = 1'b1; ex_valid = 1'b0; step();
        check("j2_link", mem_alu_result, 32'h14);
        step();

        // flush with both entries full and an incoming item
        mem_ready = 1'b0;
        send(32'h44, 9'h0, 32'h0, 6'b000010); step();
        send(32'h55, 9'h0, 32'h0, 6'b000010); step();
        check("fl_full", ex_ready, 0);
        send(32'h66, 9'h020, 32'h8, 6'b010010); flush = 1'b1; step();
        check("fl_valid", mem_valid, 0);
        check("fl_ready", ex_ready, 1);
        check("fl_redir", redirect_valid, 0);
        // flush while ready: incoming jump dropped, no redirect
        step();
        check("fl2_valid", mem_valid, 0);
        check("fl2_redir", redirect_valid, 0);
        check("fl2_rpc", redirect_pc, 9'h110);
        flush = 1'b0; ex_valid = 1'b0; step();
        check("fl_after", mem_valid, 0);

        // reset mid-backpressure with a redirect pending
        send(32'h77, 9'h040, 32'h4, 6'b010010); step();
        check("mr_redir_pre", redirect_valid, 1);
        send(32'h88, 9'h0, 32'h0, 6'b000010); step();
        check("mr_full", ex_ready, 0);
        send(32'h99, 9'h0, 32'h0, 6'b010010); step();
        reset = 1'b0; #1;
        check("mr_valid", mem_valid, 0);
        check("mr_ready", ex_ready, 1);
        check("mr_redir", redirect_valid, 0);
        check("mr_rpc", redirect_pc, 0);
        check("mr_alu", mem_alu_result, 0);
        ex_valid = 1'b0; step();
        reset = 1'b1; mem_ready = 1'b1;
        send(32'hAB, 9'h0, 32'h0, 6'b000010); step();
        check("mr_restart", mem_alu_result, 32'hAB);
        ex_valid = 1'b0; step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX→MEM pipeline stage directly downstream of the ALU in the RISC-V core.
- Registers the ALU result, store data and control through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Resolves branches and jumps from the ALU compare result and emits a single-cycle PC redirect.
- Rewrites the jump write-back value to PC+4.

Parameters:
DATA_WIDTH, 32, ALU result / store data / immediate width
PC_WIDTH, 9, instruction address width (matches the core's PC bus)
REG_ADDR_WIDTH, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
ex_valid  in  1  EX holds a valid instruction
ex_ready  out  1  stage can accept this cycle
ex_alu_result  in  DATA_WIDTH  ALU output; bit0 = compare outcome for branch ops
ex_store_data  in  DATA_WIDTH  rs2 value for stores
ex_imm  in  DATA_WIDTH  sign-extended branch/jump offset
ex_pc  in  PC_WIDTH  instruction PC
ex_rd  in  REG_ADDR_WIDTH  destination register
ex_ctrl  in  6  {is_branch, is_jump, mem_read, mem_write, reg_write, mem_unsigned}
flush  in  1  from hazard unit: discard all held and incoming entries
mem_valid  out  1  output entry valid
mem_ready  in  1  MEM consumes the entry this cycle
mem_alu_result  out  DATA_WIDTH  address / write-back value
mem_store_data  out  DATA_WIDTH  registered store data
mem_rd  out  REG_ADDR_WIDTH  registered destination
mem_ctrl  out  4  {mem_read, mem_write, reg_write, mem_unsigned}
redirect_valid  out  1  single-cycle PC redirect pulse
redirect_pc  out  PC_WIDTH  redirect target

Behaviour:
- Reset (async assert, sync release): both entries invalid, mem_valid=0, ex_ready=1, redirect_valid=0. All payload and redirect_pc outputs = 0.
- Accept happens when ex_valid & ex_ready & !flush.
- ex_ready is registered and equals !skid_valid. It depends on nothing combinationally from mem_ready.
- Entries are main (drives mem_*) and skid. Output transfer happens when mem_valid & mem_ready.
  - Main empty or transferring, skid empty: accepted item → main.
  - Main full and not transferring: accepted item → skid; ex_ready falls next cycle.
  - Transfer with skid full: skid → main. Accept is impossible because ex_ready=0.
- Latency: 1 cycle from accept to mem_valid when unblocked. Throughput: 1 per cycle with mem_ready=1.
- Order preserved. No duplication or loss under any mem_ready pattern.
- Payload stays stable while mem_valid & !mem_ready.
- Jump (is_jump=1): stored alu result = zero-extended ex_pc + 4, modulo 2^PC_WIDTH.
- Branch (is_branch=1): control passes with mem_read/mem_write/reg_write forced 0.
- Redirect:
  - Condition: on accept, taken = is_jump | (is_branch & ex_alu_result[0]).
  - Target: ex_pc + ex_imm[PC_WIDTH-1:0], wrapping modulo 2^PC_WIDTH.
  - If taken, redirect_valid=1 with redirect_pc = target in the cycle after accept, for exactly one cycle, regardless of mem_ready.
  - redirect_pc holds its last value otherwise.
- Flush:
  - Next cycle both entries are invalid, mem_valid=0, ex_ready=1.
  - The concurrent ex_valid item is dropped and produces no redirect.
  - A redirect already registered that cycle still pulses.
- Flush and mem_ready in the same cycle: the transfer completes; the remaining entries are discarded.
- Reset mid-operation: immediate clear to reset values, including a pending redirect.
- Width rule: PC math is unsigned, truncated to PC_WIDTH. ex_imm bits above PC_WIDTH-1 are ignored.

Test Plan:
- Reset with ex_valid=1, reset=0 → mem_valid=0, ex_ready=1, redirect_valid=0. After release, first item accepted.
- Stream, mem_ready=1: ex_alu_result 5,6,7 on consecutive cycles → mem_alu_result 5,6,7 on following cycles, mem_valid continuous, ex_ready stays 1.
- Backpressure: mem_ready=0, send A=0x11, B=0x22, C=0x33.
  - ex_ready=0 the cycle after B; C held at EX.
  - Raise mem_ready → outputs 0x11, 0x22, 0x33 in order, each exactly once.
- Branch: is_branch=1, ex_pc=0x010, ex_imm=0x20, alu_result=1 → redirect_valid pulse, redirect_pc=0x030, mem_ctrl write enables=0. Same with alu_result=0 → no pulse.
- Jump: is_jump=1, reg_write=1, ex_pc=0x1FC, ex_imm=0xFFFFFFF8 → redirect_pc=0x1F4, mem_alu_result=0x000 (wrap), reg_write=1.
- Flush with both entries full and ex_valid=1 → next cycle mem_valid=0, ex_ready=1, no redirect for the dropped item. Reset pulsed mid-backpressure clears identically.
